peridot_pfc_cmd_arbiter: RTL and testbench

//   Shares one PFC command/response port between NUM_REQ register-access requesters
//   (e.g. the Avalon-MM host bridge and hardware boot/config sequencers).

---
 rtl/peridot_pfc_cmd_arbiter_pkg.sv | 37 +++
 rtl/peridot_pfc_rr_picker.sv | 36 +++
 rtl/peridot_pfc_cmd_arbiter.sv | 125 ++++++++++++
 tb/tb_peridot_pfc_cmd_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/peridot_pfc_cmd_arbiter_pkg.sv
// rtl/peridot_pfc_cmd_arbiter_pkg.sv - PFC command bus layout, register map and arbiter state types
package peridot_pfc_cmd_arbiter_pkg;

    localparam int PFC_CMD_W        = 37;
    localparam int PFC_CMD_WR_BIT   = 36;
    localparam int PFC_CMD_ADDR_MSB = 35;
    localparam int PFC_CMD_ADDR_LSB = 32;
    localparam int PFC_DATA_W       = 32;
    localparam int PFC_ADDR_W       = PFC_CMD_ADDR_MSB - PFC_CMD_ADDR_LSB + 1;

    typedef enum logic [PFC_ADDR_W-1:0] {
        BANK0_DIN = 4'd0,  BANK0_DOUT = 4'd1,  BANK0_PINFUNC = 4'd2,  BANK0_FUNCPIN = 4'd3,
        BANK1_DIN = 4'd4,  BANK1_DOUT = 4'd5,  BANK1_PINFUNC = 4'd6,  BANK1_FUNCPIN = 4'd7,
        BANK2_DIN = 4'd8,  BANK2_DOUT = 4'd9,  BANK2_PINFUNC = 4'd10, BANK2_FUNCPIN = 4'd11,
        BANK3_DIN = 4'd12, BANK3_DOUT = 4'd13, BANK3_PINFUNC = 4'd14, BANK3_FUNCPIN = 4'd15
    } pfc_reg_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic logic [PFC_CMD_W-1:0] pfc_cmd_pack(
        input logic                  wr,
        input logic [PFC_ADDR_W-1:0] addr,
        input logic [PFC_DATA_W-1:0] data
    );
        logic [PFC_CMD_W-1:0] cmd;
        cmd = '0;
        cmd[PFC_CMD_WR_BIT]                     = wr;
        cmd[PFC_CMD_ADDR_MSB:PFC_CMD_ADDR_LSB]  = addr;
        cmd[PFC_DATA_W-1:0]                     = data;
        return cmd;
    endfunction

endpackage

// File: rtl/peridot_pfc_rr_picker.sv
// rtl/peridot_pfc_rr_picker.sv - combinational round-robin pick: first eligible index at or after ptr, wrapping
module peridot_pfc_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic             hi_any;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Descending scans so the last hit is the lowest index; the hi scan only
    // considers indices at or above ptr, the lo scan is the wrapped fallback.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= ptr_i) begin
                    hi_any = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
    end

    assign any_o = |eligible_i;
    assign idx_o = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/peridot_pfc_cmd_arbiter.sv
// rtl/peridot_pfc_cmd_arbiter.sv - round-robin sharing of one PFC command/response port between NUM_REQ requesters
module peridot_pfc_cmd_arbiter
    import peridot_pfc_cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 3
) (
    input  logic                      csi_clk,
    input  logic                      rsi_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [4*NUM_REQ-1:0]      req_address,
    input  logic [32*NUM_REQ-1:0]     req_writedata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [PFC_DATA_W-1:0]     req_readdata,
    output logic                      coe_pfc_clk,
    output logic                      coe_pfc_reset,
    output logic [PFC_CMD_W-1:0]      coe_pfc_cmd,
    input  logic [PFC_DATA_W-1:0]     coe_pfc_resp
);

    arb_state_e              state_q, state_d;
    logic [PFC_CMD_W-1:0]    cmd_q, cmd_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [PFC_DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0]      eligible;
    logic                    pick_any;
    logic [IDX_W-1:0]        pick_idx;
    logic                    sel_write;
    logic [PFC_ADDR_W-1:0]   sel_addr;
    logic [PFC_DATA_W-1:0]   sel_data;

    // A requester is invisible during its own ack cycle so a held request
    // is not granted twice for one access.
    assign eligible = req_valid & ~ack_q;

    peridot_pfc_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .any_o      (pick_any),
        .idx_o      (pick_idx)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_address[4*i +: 4];
                sel_data  = req_writedata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_any) state_d = ST_CMD;
            ST_CMD:  state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Address and data stay on the bus after the access; only the strobe drops.
    always_comb begin
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    cmd_d = pfc_cmd_pack(sel_write, sel_addr, sel_data);
                    idx_d = pick_idx;
                end
            end
            ST_CMD: begin
                cmd_d[PFC_CMD_WR_BIT] = 1'b0;
            end
            ST_RESP: begin
                rdata_d = coe_pfc_resp;
                ack_d   = NUM_REQ'(1) << idx_q;
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
            end
            default: begin
                cmd_d[PFC_CMD_WR_BIT] = 1'b0;
            end
        endcase
    end

    assign req_ack       = ack_q;
    assign req_readdata  = rdata_q;
    assign coe_pfc_cmd   = cmd_q;
    assign coe_pfc_clk   = csi_clk;
    assign coe_pfc_reset = ~rsi_reset_n;

endmodule

// File: tb/tb_peridot_pfc_cmd_arbiter.sv
// tb/tb_peridot_pfc_cmd_arbiter.sv - directed and randomized checks of the PFC command arbiter against a transaction-level model
module tb_peridot_pfc_cmd_arbiter;

    localparam int N    = 3;
    localparam int HMAX = 4096;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [4*N-1:0]  req_address;
    logic [32*N-1:0] req_writedata;
    logic [N-1:0]    req_ack;
    logic [31:0]     req_readdata;
    logic            coe_pfc_clk;
    logic            coe_pfc_reset;
    logic [36:0]     coe_pfc_cmd;
    logic [31:0]     coe_pfc_resp;

    always #5 clk = ~clk;

    function automatic logic [31:0] pfc_model(input logic [3:0] a);
        return (a == 4'd8) ? 32'h0000_00A5 : (32'h1234_5600 | {28'd0, a});
    endfunction

    assign coe_pfc_resp = pfc_model(coe_pfc_cmd[35:32]);

    peridot_pfc_cmd_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (3)
    ) dut (
        .csi_clk       (clk),
        .rsi_reset_n   (rst_n),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_address   (req_address),
        .req_writedata (req_writedata),
        .req_ack       (req_ack),
        .req_readdata  (req_readdata),
        .coe_pfc_clk   (coe_pfc_clk),
        .coe_pfc_reset (coe_pfc_reset),
        .coe_pfc_cmd   (coe_pfc_cmd),
        .coe_pfc_resp  (coe_pfc_resp)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [36:0]     cmd_h  [HMAX];
    logic [N-1:0]    ack_h  [HMAX];
    logic [N-1:0]    vld_h  [HMAX];
    logic [N-1:0]    wr_h   [HMAX];
    logic [4*N-1:0]  addr_h [HMAX];
    logic [32*N-1:0] data_h [HMAX];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs driven after sample k are what the DUT sees at the next rising edge.
    task automatic tick();
        if (cyc < HMAX) begin
            vld_h[cyc]  = req_valid;
            wr_h[cyc]   = req_write;
            addr_h[cyc] = req_address;
            data_h[cyc] = req_writedata;
        end
        @(negedge clk);
        cyc++;
        if (cyc < HMAX) begin
            cmd_h[cyc] = coe_pfc_cmd;
            ack_h[cyc] = req_ack;
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [3:0] a, input logic [31:0] d);
        req_valid[i]            = v;
        req_write[i]            = w;
        req_address[4*i +: 4]   = a;
        req_writedata[32*i +: 32] = d;
    endtask

    task automatic wait_ack(input string tag, input int budget, output int at);
        at = -1;
        for (int t = 0; t < budget; t++) begin
            tick();
            if (req_ack != '0) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        assert (at >= 0) else begin
            n_fail++;
            $error("FAIL %s_timeout: observed no ack within %0d cycles, expected an ack", tag, budget);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] e, input int p);
        for (int o = 0; o < N; o++) begin
            int j;
            j = (p + o) % N;
            if (e[j]) return j;
        end
        return -1;
    endfunction

    initial begin
        int k, at, prev, strobes, model_ptr, a_prev, nacc, nwr, rstart, w, g, idle_bad;
        logic [N-1:0] acc_ack;
        logic [3:0]   ta [N];
        logic [31:0]  td [N];

        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_address = '0; req_writedata = '0;

        // Reset: random requests must not reach the bus
        for (int r = 0; r < 4; r++) begin
            req_valid = N'($urandom);
            req_write = N'($urandom);
            req_writedata = {$urandom, $urandom, $urandom};
            tick();
            chk("rst_cmd", 64'(coe_pfc_cmd), 64'd0);
            chk("rst_ack", 64'(req_ack), 64'd0);
            chk("rst_rdata", 64'(req_readdata), 64'd0);
            chk("rst_pfc_reset", 64'(coe_pfc_reset), 64'd1);
        end

        // Contention: all three hold reads; first grant after release goes to 0
        for (int i = 0; i < N; i++) begin
            ta[i] = 4'(i + 1);
            td[i] = 32'hC0DE_0000 | 32'(i);
            set_req(i, 1'b1, 1'b0, ta[i], td[i]);
        end
        k = cyc;
        rst_n = 1'b1;
        prev = k;
        for (int j = 0; j < 6; j++) begin
            w = j % N;
            wait_ack("t4", 8, at);
            if (at < 3) break;
            chk("t4_ack_idx", 64'(req_ack), 64'(1) << w);
            chk("t4_ack_gap", 64'(at - prev), 64'd3);
            chk("t4_cmd", 64'(cmd_h[at-2]), 64'({1'b0, ta[w], td[w]}));
            chk("t4_rdata", 64'(req_readdata), 64'(pfc_model(ta[w])));
            prev = at;
        end
        req_valid = '0;
        acc_ack = '0;
        for (int t = 0; t < 4; t++) begin
            tick();
            acc_ack |= req_ack;
        end
        chk("t4_quiet_ack", 64'(acc_ack), 64'd0);

        // Single write from requester 0
        set_req(0, 1'b1, 1'b1, 4'd5, 32'h0000_FF12);
        k = cyc;
        wait_ack("t2", 8, at);
        req_valid = '0;
        chk("t2_latency", 64'(at - k), 64'd3);
        chk("t2_ack", 64'(req_ack), 64'b001);
        chk("t2_cmd_strobe", 64'(cmd_h[k+1]), 64'(37'h15_0000_FF12));
        chk("t2_cmd_resp", 64'(cmd_h[k+2]), 64'(37'h05_0000_FF12));
        chk("t2_cmd_idle", 64'(cmd_h[k+3]), 64'(37'h05_0000_FF12));
        chk("t2_rdata", 64'(req_readdata), 64'(pfc_model(4'd5)));
        tick();

        // Single read from requester 1
        set_req(1, 1'b1, 1'b0, 4'd8, 32'hFFFF_FFFF);
        k = cyc;
        wait_ack("t3", 8, at);
        req_valid = '0;
        chk("t3_latency", 64'(at - k), 64'd3);
        chk("t3_ack", 64'(req_ack), 64'b010);
        chk("t3_rdata", 64'(req_readdata), 64'h0000_00A5);
        strobes = 0;
        for (int c = k + 1; c <= k + 3; c++) strobes += int'(cmd_h[c][36]);
        chk("t3_no_strobe", 64'(strobes), 64'd0);
        tick();

        // Held request: no re-grant in the ack cycle
        set_req(0, 1'b1, 1'b0, 4'd2, 32'h0);
        k = cyc;
        wait_ack("t5a", 8, at);
        chk("t5_first_latency", 64'(at - k), 64'd3);
        prev = at;
        wait_ack("t5b", 8, at);
        req_valid = '0;
        chk("t5_second_gap", 64'(at - prev), 64'd4);
        chk("t5_second_ack", 64'(req_ack), 64'b001);
        tick();
        tick();

        // Reset during the strobe cycle of a write
        set_req(0, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
        tick();
        chk("t6_strobe_up", 64'(coe_pfc_cmd[36]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_strobe_cut", 64'(coe_pfc_cmd[36]), 64'd0);
        chk("t6_pfc_reset", 64'(coe_pfc_reset), 64'd1);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        acc_ack = '0;
        for (int t = 0; t < 6; t++) begin
            tick();
            acc_ack |= req_ack;
        end
        chk("t6_no_ack", 64'(acc_ack), 64'd0);
        set_req(0, 1'b1, 1'b0, 4'd9, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'd10, 32'h0);
        wait_ack("t6_ptr", 8, at);
        req_valid[0] = 1'b0;
        chk("t6_ptr_reset", 64'(req_ack), 64'b001);
        wait_ack("t6_ptr2", 8, at);
        req_valid = '0;
        chk("t6_second", 64'(req_ack), 64'b010);

        // Randomized traffic against the round-robin transaction model
        model_ptr = 2;
        a_prev = at;
        nacc = 0;
        nwr = 0;
        idle_bad = 0;
        rstart = cyc;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t >= 390) begin
                    req_valid[i] = 1'b0;
                end else if (req_ack[i] || !req_valid[i]) begin
                    if ((req_ack[i] && $urandom_range(1, 0) == 1) || (!req_ack[i] && !req_valid[i] && $urandom_range(2, 0) == 0))
                        set_req(i, 1'b1, 1'($urandom), 4'($urandom), $urandom);
                    else
                        req_valid[i] = 1'b0;
                end
            end
            tick();
            if (req_ack != '0 && cyc >= 4) begin
                g = cyc - 3;
                w = rr_pick(vld_h[g] & ~ack_h[g], model_ptr);
                if (w < 0) begin
                    chk("rnd_unexpected_ack", 64'(req_ack), 64'd0);
                end else begin
                    chk("rnd_winner", 64'(req_ack), 64'(1) << w);
                    chk("rnd_cmd", 64'(cmd_h[g+1]), 64'({wr_h[g][w], addr_h[g][4*w +: 4], data_h[g][32*w +: 32]}));
                    chk("rnd_resp_cmd", 64'(cmd_h[g+2]), 64'({1'b0, addr_h[g][4*w +: 4], data_h[g][32*w +: 32]}));
                    chk("rnd_rdata", 64'(req_readdata), 64'(pfc_model(addr_h[g][4*w +: 4])));
                    for (int c = a_prev; c < g; c++)
                        if ((vld_h[c] & ~ack_h[c]) != '0) idle_bad++;
                    model_ptr = (w + 1) % N;
                    nacc++;
                    if (wr_h[g][w]) nwr++;
                end
                a_prev = cyc;
            end
        end
        chk("rnd_work_conserving", 64'(idle_bad), 64'd0);
        strobes = 0;
        for (int c = rstart + 1; c <= cyc; c++) strobes += int'(cmd_h[c][36]);
        chk("rnd_strobe_count", 64'(strobes), 64'(nwr));
        chk("rnd_some_traffic", 64'(nacc > 20), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
